// File: rtl/pio_seq_if.sv
// pio_seq_if: CPU slave register bus, interrupt pair and IO-port master bus of pio_seq
//   slave  : the pio_seq side (decodes addr, drives bus_out/req_bus/intr and the m_* write)
//   master : the CPU / host side
interface pio_seq_if #(
    parameter int BUS_ADDR_DATA_LEN = 16
);
    logic [BUS_ADDR_DATA_LEN-1:0] addr;
    logic                         wr;
    logic                         rd;
    logic [7:0]                   bus_in;
    logic [7:0]                   bus_out;
    logic                         req_bus;
    logic                         intr;
    logic                         int_rst;
    logic                         m_req;
    logic                         m_gnt;
    logic [BUS_ADDR_DATA_LEN-1:0] m_addr;
    logic                         m_wr;
    logic [7:0]                   m_data;

    modport slave (
        input  addr, wr, rd, bus_in, int_rst, m_gnt,
        output bus_out, req_bus, intr, m_req, m_addr, m_wr, m_data
    );

    modport master (
        output addr, wr, rd, bus_in, int_rst, m_gnt,
        input  bus_out, req_bus, intr, m_req, m_addr, m_wr, m_data
    );
endinterface

// File: rtl/pio_seq.sv
// pio_seq: byte-pattern sequencer that replays a FIFO of bytes onto a parallel-IO port
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pio_seq_if.slave -- register slave (addr/wr/rd/bus_in/bus_out/req_bus),
//          interrupt (intr/int_rst) and IO-port master write (m_req/m_gnt/m_addr/m_wr/m_data)
module pio_seq #(
    parameter int ADDRESS           = 0,
    parameter int PIO_ADDRESS       = 0,
    parameter int BUS_ADDR_DATA_LEN = 16,
    parameter int DEPTH             = 8
) (
    input logic      clk,
    input logic      rst,
    pio_seq_if.slave bus
);
    localparam int AW = BUS_ADDR_DATA_LEN;
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]    state;
    logic          en, loop, inten, ovf, donef;
    logic [15:0]   presc, cnt;
    logic [4:0]    target, tgt;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rptr, wptr;
    logic [PW:0]   count;

    logic       sel, w_ctrl, w_stat, w_pl, w_ph, w_data, w_tgt;
    logic       flush, en_nxt, pop, lp, push_ok, we, empty, full, done_set;
    logic [7:0] head, rdata;

    assign sel = ({1'b0, bus.addr} >= (AW+1)'(ADDRESS)) && ({1'b0, bus.addr} < (AW+1)'(ADDRESS + 8));

    assign w_ctrl = bus.wr && sel && bus.addr[2:0] == 3'd0;
    assign w_stat = bus.wr && sel && bus.addr[2:0] == 3'd1;
    assign w_pl   = bus.wr && sel && bus.addr[2:0] == 3'd2;
    assign w_ph   = bus.wr && sel && bus.addr[2:0] == 3'd3;
    assign w_data = bus.wr && sel && bus.addr[2:0] == 3'd4;
    assign w_tgt  = bus.wr && sel && bus.addr[2:0] == 3'd5;

    // Abort decisions look at the EN value being written this cycle so a
    // clear lands on the very next edge.
    assign flush  = w_ctrl && bus.bus_in[2];
    assign en_nxt = w_ctrl ? bus.bus_in[0] : en;

    assign empty = count == '0;
    assign full  = count == (PW+1)'(DEPTH);
    assign head  = mem[rptr];
    assign pop   = state == S_WRITE;
    // In loop mode the popped head is re-pushed, which owns the tail slot this cycle.
    assign lp       = pop && loop;
    assign push_ok  = w_data && !full && !lp;
    assign we       = !flush && (lp || push_ok);
    assign done_set = pop && !loop && !push_ok && count == (PW+1)'(1);

    always_comb begin
        rdata = 8'h00;
        if (bus.rd && sel)
            case (bus.addr[2:0])
                3'd0:    rdata = {4'b0, inten, 1'b0, loop, en};
                3'd1:    rdata = {3'b0, donef, ovf, state != S_IDLE, full, empty};
                3'd2:    rdata = presc[7:0];
                3'd3:    rdata = presc[15:8];
                3'd4:    rdata = empty ? 8'h00 : head;
                3'd5:    rdata = {3'b0, target};
                default: rdata = 8'h00;
            endcase
    end

    assign bus.bus_out = rdata;
    assign bus.req_bus = sel;
    assign bus.intr    = inten && donef;
    assign bus.m_req   = state == S_REQ || state == S_WRITE;
    assign bus.m_wr    = pop;
    assign bus.m_addr  = pop ? AW'(PIO_ADDRESS) + AW'(tgt) : '0;
    assign bus.m_data  = pop ? head : 8'h00;

    always_ff @(posedge clk)
        if (we) mem[wptr] <= lp ? head : bus.bus_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            en     <= 1'b0;
            loop   <= 1'b0;
            inten  <= 1'b0;
            presc  <= '0;
            cnt    <= '0;
            target <= 5'h04;
            tgt    <= 5'h04;
            ovf    <= 1'b0;
            donef  <= 1'b0;
            rptr   <= '0;
            wptr   <= '0;
            count  <= '0;
        end else begin
            if (w_ctrl) {inten, loop, en} <= {bus.bus_in[3], bus.bus_in[1], bus.bus_in[0]};
            if (w_pl) presc[7:0] <= bus.bus_in;
            if (w_ph) presc[15:8] <= bus.bus_in;
            if (w_tgt) target <= bus.bus_in[4:0];
            ovf   <= (ovf || (w_data && (full || lp))) && !(w_stat && bus.bus_in[3]);
            donef <= (donef || done_set) && !(w_stat && bus.bus_in[4]) && !bus.int_rst;
            if (flush) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (we) wptr <= wptr + 1'b1;
                if (pop) rptr <= rptr + 1'b1;
                count <= count + (PW+1)'(push_ok) - (PW+1)'(pop && !loop);
            end
            // PRESC and TARGET are sampled only when leaving IDLE.
            case (state)
                S_IDLE:
                    if (en && !flush && !empty) begin
                        state <= S_WAIT;
                        cnt   <= presc;
                        tgt   <= target;
                    end
                S_WAIT:
                    if (!en_nxt || flush) state <= S_IDLE;
                    else if (cnt == 16'd0) state <= S_REQ;
                    else cnt <= cnt - 16'd1;
                S_REQ:
                    if (!en_nxt || flush) state <= S_IDLE;
                    else if (bus.m_gnt) state <= S_WRITE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/pio_seq.md
PIO_SEQ -- requirements
Module: pio_seq

Interface
REQ-001 Parameter ADDRESS, default 0, slave register base address on the I/O bus.
REQ-002 Parameter PIO_ADDRESS, default 0, base address of the target parallel-IO port.
REQ-003 Parameter BUS_ADDR_DATA_LEN, default 16, I/O bus address width.
REQ-004 Parameter DEPTH, default 8 (power of two, 2..16), pattern FIFO depth in bytes.
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 addr  in  BUS_ADDR_DATA_LEN  slave bus address.
REQ-009 wr / rd  in  1 each  slave write / read strobes.
REQ-010 bus_in  in  8  slave write data.
REQ-011 bus_out  out  8  slave read data, combinational.
REQ-012 req_bus  out  1  high when ADDRESS <= addr < ADDRESS+8.
REQ-013 int  out  1  level interrupt; int_rst  in  1  interrupt acknowledge pulse.
REQ-014 m_req  out  1  master bus request; m_gnt  in  1  master bus grant.
REQ-015 m_addr  out  BUS_ADDR_DATA_LEN, m_wr  out  1, m_data  out  8  master write to the IO port.

Function
REQ-016 Registers (addr[2:0]): 0 CTRL {bit0 EN, bit1 LOOP, bit2 FLUSH, bit3 INTEN}; 1 STATUS {bit0 EMPTY, bit1 FULL, bit2 BUSY, bit3 OVF, bit4 DONEF}; 2 PRESC_L; 3 PRESC_H; 4 DATA; 5 TARGET[4:0]; 6-7 reserved, read 0.
REQ-017 Slave write effective when wr && req_bus; read returns register when rd && req_bus, else bus_out = 0.
REQ-018 FLUSH is self-clearing: write 1 empties FIFO next cycle, reads 0.
REQ-019 STATUS OVF and DONEF are write-1-to-clear; other STATUS bits read-only.
REQ-020 Write to DATA pushes one byte; push when FULL is dropped and sets OVF.
REQ-021 Read of DATA returns FIFO head without popping; 0 when EMPTY.
REQ-022 FSM states IDLE, WAIT, REQ, WRITE; BUSY = state != IDLE.
REQ-023 IDLE -> WAIT when EN=1 and FIFO not empty; counter loaded with {PRESC_H,PRESC_L}.
REQ-024 WAIT decrements counter each cycle; -> REQ in the cycle counter == 0 (WAIT lasts PRESC+1 cycles).
REQ-025 REQ holds m_req=1 until m_gnt sampled high, then -> WRITE.
REQ-026 WRITE lasts one cycle: m_req=1, m_wr=1, m_addr = PIO_ADDRESS + TARGET, m_data = FIFO head; head popped; -> IDLE.
REQ-027 Outside WRITE: m_wr=0, m_addr=0, m_data=0; m_req=0 outside REQ/WRITE.
REQ-028 With immediate grant, byte-to-byte period SHALL be PRESC+4 cycles.
REQ-029 LOOP=1: popped byte re-pushed to tail in the same cycle, count unchanged; a CPU DATA write in that cycle is dropped and sets OVF.
REQ-030 LOOP=0: simultaneous CPU push and pop both take effect, count unchanged; push while FULL still dropped.
REQ-031 Pop leaving FIFO empty (LOOP=0) sets DONEF.
REQ-032 int = INTEN && DONEF; int_rst high clears DONEF, priority over a same-cycle set.
REQ-033 EN cleared in WAIT or REQ: return to IDLE next cycle, no write, FIFO untouched; EN cleared in WRITE: write completes.
REQ-034 FLUSH during WAIT/REQ aborts to IDLE; FLUSH during WRITE completes the write, then FIFO empty.
REQ-035 PRESC/TARGET writes during WAIT take effect at next WAIT load.
REQ-036 FIFO pointers wrap modulo DEPTH; count width log2(DEPTH)+1.

Reset
REQ-037 On rst low: state IDLE, FIFO empty, CTRL=0, PRESC=0, TARGET=5'h04, OVF=0, DONEF=0, counter=0.
REQ-038 During reset: m_req=0, m_wr=0, m_addr=0, m_data=0, int=0; bus_out combinational per REQ-017.
REQ-039 rst asserted mid-transfer aborts immediately; no partial write after release.

Verification
REQ-040 Push 8'hA5,8'h5A, PRESC=2, EN=1, m_gnt tied 1 -> two writes to PIO_ADDRESS+4, 6 cycles apart, then DONEF=1, EMPTY=1.
REQ-041 INTEN=1 after REQ-040 -> int=1; int_rst pulse -> int=0, DONEF=0.
REQ-042 m_gnt held low 10 cycles in REQ -> m_req stays 1, no m_wr; m_gnt=1 -> single m_wr next cycle.
REQ-043 Push DEPTH+1 bytes -> FULL=1, OVF=1, last byte lost; write 8'h08 to STATUS -> OVF=0.
REQ-044 LOOP=1 with 3 bytes, PRESC=0 -> written sequence repeats 1,2,3,1,2,3, count stays 3.
REQ-045 Clear EN during WAIT -> no m_req, FIFO count unchanged; rst low during REQ -> all outputs 0, FIFO empty.
